wb_tracker: RTL and testbench

- Downstream neighbour of the EX-stage tracker. Consumes completed EX trace elements (ex_data_ready / ex_data_i) and buffers them in order.
- Timestamps each element's writeback phase, plus the memory response phase for elements that made a data access.
- Emits finished trace elements to the trace output sink as single-cycle pulses.

---
 rtl/wb_tracker_if.sv | 44 ++++
 rtl/wb_tracker.sv | 132 +++++++++++++
 tb/tb_wb_tracker.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_tracker_if.sv
// Trace element types and the bus bundle shared by the EX tracker side, the WB tracker
// and the trace sink.
package wb_tracker_pkg;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
  } phase_stamp;

  typedef struct packed {
    logic [7:0]  id;
    logic        pass_through;
    phase_stamp  mem_access_req;
    phase_stamp  mem_access_res;
    logic [31:0] time_start;
    logic [31:0] time_end;
  } trace_output;

endpackage

interface wb_tracker_if;
  import wb_tracker_pkg::*;

  logic [31:0] counter;
  logic        ex_data_ready;
  trace_output ex_data_i;
  logic        data_rvalid_i;
  logic        wb_ready;
  trace_output wb_data_o;
  logic        wb_data_ready;
  logic        queue_full;
  logic        overflow;

  modport master (
    output counter, ex_data_ready, ex_data_i, data_rvalid_i, wb_ready,
    input  wb_data_o, wb_data_ready, queue_full, overflow
  );

  modport slave (
    input  counter, ex_data_ready, ex_data_i, data_rvalid_i, wb_ready,
    output wb_data_o, wb_data_ready, queue_full, overflow
  );

endinterface

// File: rtl/wb_tracker.sv
// Writeback-stage trace tracker: queues EX trace elements in order, stamps their
// writeback / memory response phases and emits each one as a single-cycle pulse.
//   state          | meaning
//   WB_IDLE        | waiting for a queued element to pop into the working register
//   WB_WAIT_RVALID | memory-access element waiting for the data response
//   WB_WAIT_READY  | waiting for the WB stage to complete the instruction
//   WB_EMIT        | working register is pushed to the output on the next edge
module wb_tracker
  import wb_tracker_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_WIDTH   = $clog2(QUEUE_DEPTH)
) (
  input logic         clk,
  input logic         rst,
  wb_tracker_if.slave bus
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_RVALID,
    WB_WAIT_READY,
    WB_EMIT
  } wb_state;

  wb_state              state;
  wb_state              state_next;
  trace_output          queue [QUEUE_DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH:0]   count;
  trace_output          work;
  trace_output          work_next;
  trace_output          head;
  trace_output          data_q;
  logic                 ready_q;
  logic                 overflow_q;
  logic                 pop;
  logic                 push;
  logic                 emit;

  assign head = queue[rd_ptr];
  assign pop  = (state == WB_IDLE) && (count != '0);
  // A pop on the same edge frees a slot, so a push while full is still accepted.
  assign push = bus.ex_data_ready && ((count != FULL_COUNT) || pop);

  always_comb begin
    state_next = state;
    work_next  = work;
    emit       = 1'b0;
    case (state)
      WB_IDLE: begin
        if (pop) begin
          work_next            = head;
          work_next.time_start = bus.counter;
          if (head.pass_through) begin
            work_next.time_end = bus.counter;
            state_next         = WB_EMIT;
          end else if (head.mem_access_req.time_end != '0) begin
            work_next.mem_access_res.time_start = bus.counter;
            state_next                          = WB_WAIT_RVALID;
          end else begin
            state_next = WB_WAIT_READY;
          end
        end
      end
      WB_WAIT_RVALID: begin
        if (bus.data_rvalid_i) begin
          work_next.mem_access_res.time_end = bus.counter;
          state_next                        = WB_WAIT_READY;
        end
      end
      WB_WAIT_READY: begin
        if (bus.wb_ready) begin
          work_next.time_end = bus.counter;
          state_next         = WB_EMIT;
        end
      end
      WB_EMIT: begin
        emit       = 1'b1;
        state_next = WB_IDLE;
      end
      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WB_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      work       <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue[i] <= '0;
      end
    end else begin
      state   <= state_next;
      work    <= work_next;
      ready_q <= emit;
      if (emit) begin
        data_q <= work;
      end
      if (push) begin
        queue[wr_ptr] <= bus.ex_data_i;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (bus.ex_data_ready && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.wb_data_o     = data_q;
  assign bus.wb_data_ready = ready_q;
  assign bus.queue_full    = (count == FULL_COUNT);
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_wb_tracker.sv
// Bench for wb_tracker: directed vector table, hand-written overflow / reset / wrap
// sequences, and a randomized run scored against a transaction-level timeline model.
module tb_wb_tracker;
  import wb_tracker_pkg::*;

  localparam int DEPTH = 4;
  localparam int NT    = 800;
  localparam int NRAND = 700;
  localparam int INF   = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_tracker_if bus ();

  wb_tracker #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cap;
    logic pass;
    int   req_end;
    int   rv_a;
    int   rv_b;
    int   rdy_a;
    int   rdy_b;
    logic rdy_hold;
    int   ts;
    int   te;
    int   rs;
    int   re;
    int   pulse;
  } vec_t;

  vec_t vecs [6];

  int unsigned cnt    [NT+2];
  bit          ex_rdy [NT+2];
  trace_output ex_d   [NT+2];
  bit          rv     [NT+2];
  bit          rdy    [NT+2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_d(input string name, input trace_output act, input trace_output exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int c, input bit push, input trace_output d,
                       input bit rvalid, input bit ready);
    bus.counter       = 32'(c);
    bus.ex_data_ready = push;
    bus.ex_data_i     = d;
    bus.data_rvalid_i = rvalid;
    bus.wb_ready      = ready;
  endtask

  function automatic trace_output mk(input int id, input bit pass, input int req_end);
    trace_output d;
    d                           = '0;
    d.id                        = 8'(id);
    d.pass_through              = pass;
    d.mem_access_req.time_start = (req_end != 0) ? 32'd1 : 32'd0;
    d.mem_access_req.time_end   = 32'(req_end);
    d.time_start                = 32'hdead_0000 + 32'(id);
    d.time_end                  = 32'hbeef_0000 + 32'(id);
    return d;
  endfunction

  function automatic int next_hit(input bit use_rdy, input int from);
    for (int e = from; e <= NT; e++) begin
      if (use_rdy ? rdy[e] : rv[e]) return e;
    end
    return INF;
  endfunction

  initial begin
    int          got_e [$];
    trace_output got_d [$];
    int          exp_e [$];
    trace_output exp_d [$];
    int          acc_pop [$];
    int          ids [$];
    bit          any_drop;
    int          prev_pulse;

    // cap, pass, req_end, rv_a, rv_b, rdy_a, rdy_b, hold, ts, te, rs, re, pulse
    vecs[0] = '{10, 1'b1, 0, -1, -1, -1, -1, 1'b0, 11, 11,  0,  0, 12};
    vecs[1] = '{20, 1'b0, 0, -1, -1, 21, -1, 1'b1, 21, 22,  0,  0, 23};
    vecs[2] = '{30, 1'b0, 5, 34, -1, 36, -1, 1'b0, 31, 36, 31, 34, 37};
    vecs[3] = '{40, 1'b0, 7, 41, 43, 43, 45, 1'b0, 41, 45, 41, 43, 46};
    vecs[4] = '{50, 1'b0, 0, -1, -1, 51, 54, 1'b0, 51, 54,  0,  0, 55};
    vecs[5] = '{60, 1'b1, 9, -1, -1, -1, -1, 1'b0, 61, 61,  0,  0, 62};

    drive(0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", bus.wb_data_ready, 0);
    check("reset_full", bus.queue_full, 0);
    check("reset_overflow", bus.overflow, 0);
    check_d("reset_data", bus.wb_data_o, '0);
    rst = 1'b0;
    tick();

    // Directed single-element vectors.
    for (int v = 0; v < 6; v++) begin
      bit seen;
      seen = 1'b0;
      for (int c = vecs[v].cap; c <= vecs[v].cap + 20; c++) begin
        drive(c, c == vecs[v].cap, mk(v, vecs[v].pass, vecs[v].req_end),
              (c == vecs[v].rv_a) || (c == vecs[v].rv_b),
              (c == vecs[v].rdy_a) || (c == vecs[v].rdy_b) ||
              (vecs[v].rdy_hold && c >= vecs[v].rdy_a));
        tick();
        if (bus.wb_data_ready) begin
          seen = 1'b1;
          check($sformatf("vec%0d_pulse", v), c, vecs[v].pulse);
          check($sformatf("vec%0d_id", v), bus.wb_data_o.id, v);
          check($sformatf("vec%0d_ts", v), bus.wb_data_o.time_start, vecs[v].ts);
          check($sformatf("vec%0d_te", v), bus.wb_data_o.time_end, vecs[v].te);
          check($sformatf("vec%0d_rs", v), bus.wb_data_o.mem_access_res.time_start, vecs[v].rs);
          check($sformatf("vec%0d_re", v), bus.wb_data_o.mem_access_res.time_end, vecs[v].re);
          break;
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL vec%0d_timeout: got no pulse expected pulse at %0d", v, vecs[v].pulse);
      end
      drive(vecs[v].cap + 30, 1'b0, '0, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_single_cycle", v), bus.wb_data_ready, 0);
      check($sformatf("vec%0d_hold", v), bus.wb_data_o.time_end, seen ? vecs[v].te : 0);
    end

    // Overflow: stall WB, push six elements back-to-back; the sixth is dropped.
    for (int k = 0; k < 6; k++) begin
      drive(100 + k, 1'b1, mk(k, 1'b0, 0), 1'b0, 1'b0);
      tick();
      check($sformatf("ovf_full_%0d", k), bus.queue_full, (k >= 4) ? 1 : 0);
      check($sformatf("ovf_flag_%0d", k), bus.overflow, (k >= 5) ? 1 : 0);
    end
    ids.delete();
    for (int k = 0; k < 60; k++) begin
      drive(110 + k, 1'b0, '0, 1'b0, 1'b1);
      tick();
      if (bus.wb_data_ready) ids.push_back(int'(bus.wb_data_o.id));
    end
    check("ovf_emit_count", ids.size(), 5);
    foreach (ids[i]) check($sformatf("ovf_order_%0d", i), ids[i], i);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_full_drained", bus.queue_full, 0);

    // Reset while a memory-access element waits for rvalid and the queue is full.
    drive(200, 1'b1, mk(20, 1'b0, 5), 1'b0, 1'b0);
    tick();
    for (int k = 1; k < 5; k++) begin
      drive(200 + k, 1'b1, mk(20 + k, 1'b0, 0), 1'b0, 1'b0);
      tick();
    end
    check("rstmid_full_before", bus.queue_full, 1);
    drive(210, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rstmid_ready", bus.wb_data_ready, 0);
    check("rstmid_full", bus.queue_full, 0);
    check("rstmid_overflow", bus.overflow, 0);
    check_d("rstmid_data", bus.wb_data_o, '0);
    @(negedge clk);
    rst = 1'b0;
    ids.delete();
    for (int k = 0; k < 15; k++) begin
      drive(220 + k, 1'b0, '0, 1'b1, 1'b1);
      tick();
      if (bus.wb_data_ready) ids.push_back(int'(bus.wb_data_o.id));
    end
    check("rstmid_no_emit", ids.size(), 0);

    // Wrap-around: twelve plain elements, one every third edge, WB always ready.
    ids.delete();
    for (int k = 0; k < 12 * 3 + 10; k++) begin
      drive(300 + k, (k % 3 == 0) && (k / 3 < 12), mk(k / 3, 1'b0, 0), 1'b0, 1'b1);
      tick();
      if (bus.wb_data_ready) ids.push_back(int'(bus.wb_data_o.id));
    end
    check("wrap_count", ids.size(), 12);
    foreach (ids[i]) check($sformatf("wrap_order_%0d", i), ids[i], i);
    check("wrap_overflow", bus.overflow, 0);

    // Randomized run against an element-timeline model.
    for (int e = 1; e <= NT; e++) begin
      trace_output d;
      cnt[e] = 32'(1000 + e);
      d                           = '0;
      d.id                        = 8'(e);
      d.pass_through              = ($urandom_range(0, 3) == 0);
      d.mem_access_req.time_start = $urandom;
      d.mem_access_req.time_end   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 500)) : 32'd0;
      d.mem_access_res.time_start = $urandom;
      d.mem_access_res.time_end   = $urandom;
      d.time_start                = $urandom;
      d.time_end                  = $urandom;
      ex_d[e] = d;
      if (e <= NRAND) begin
        ex_rdy[e] = ($urandom_range(0, 99) < 45);
        rv[e]     = ($urandom_range(0, 99) < 30);
        rdy[e]    = ($urandom_range(0, 99) < 40);
      end else begin
        ex_rdy[e] = 1'b0;
        rv[e]     = 1'b1;
        rdy[e]    = 1'b1;
      end
    end

    drive(0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= NT; e++) begin
      drive(int'(cnt[e]), ex_rdy[e], ex_d[e], rv[e], rdy[e]);
      tick();
      if (bus.wb_data_ready) begin
        got_e.push_back(e);
        got_d.push_back(bus.wb_data_o);
      end
    end

    any_drop   = 1'b0;
    prev_pulse = 0;
    for (int e = 1; e <= NT; e++) begin
      if (ex_rdy[e]) begin
        int          occ;
        bit          pop_now;
        int          pop;
        int          w;
        int          pulse;
        trace_output d;
        occ     = 0;
        pop_now = 1'b0;
        foreach (acc_pop[i]) begin
          if (acc_pop[i] >= e) occ++;
          if (acc_pop[i] == e) pop_now = 1'b1;
        end
        if (occ == DEPTH && !pop_now) begin
          any_drop = 1'b1;
          continue;
        end
        pop   = (prev_pulse >= INF) ? INF : ((e + 1 > prev_pulse + 1) ? e + 1 : prev_pulse + 1);
        pulse = INF;
        d     = ex_d[e];
        if (pop <= NT) begin
          d.time_start = cnt[pop];
          if (d.pass_through) begin
            d.time_end = cnt[pop];
            pulse      = pop + 1;
          end else begin
            w = pop;
            if (d.mem_access_req.time_end != 0) begin
              d.mem_access_res.time_start = cnt[pop];
              w = next_hit(1'b0, pop + 1);
              if (w < INF) d.mem_access_res.time_end = cnt[w];
            end
            if (w < INF) begin
              w = next_hit(1'b1, w + 1);
              if (w < INF) begin
                d.time_end = cnt[w];
                pulse      = w + 1;
              end
            end
          end
        end
        if (pulse <= NT) begin
          exp_e.push_back(pulse);
          exp_d.push_back(d);
        end
        acc_pop.push_back(pop);
        prev_pulse = pulse;
      end
    end

    check("rand_emit_count", got_e.size(), exp_e.size());
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
      check($sformatf("rand_edge_%0d", i), got_e[i], exp_e[i]);
      check_d($sformatf("rand_data_%0d", i), got_d[i], exp_d[i]);
    end
    check("rand_overflow", bus.overflow, any_drop);
    check("rand_full_end", bus.queue_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
